pairhmm_job_dispatcher: RTL and testbench
=========================================

PAIRHMM_JOB_DISPATCHER -- requirements
Module: pairhmm_job_dispatcher

Interface
REQ-001 SHALL have parameter NUM_WG, default 4, number of downstream workgroups (2..16).
REQ-002 SHALL have parameter JOB_W, default 256, width of a packed work request.
REQ-003 SHALL have parameter RES_W, default 64, width of a packed final result.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum jobs in flight per workgroup (1..15).
REQ-005 clock  in  1  clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 job_tvalid_i / job_tready_o / job_tdata_i  in/out/in  1/1/JOB_W  upstream job stream.
REQ-008 wg_job_tvalid_o / wg_job_tready_i  out/in  NUM_WG each  per-workgroup job handshake.
REQ-009 wg_job_tdata_o  out  JOB_W  job payload, shared by all workgroups.
REQ-010 wg_res_tvalid_i / wg_res_tready_o  in/out  NUM_WG each  per-workgroup result handshake.
REQ-011 wg_res_tdata_i  in  NUM_WG*RES_W  results; workgroup k in slice [k*RES_W +: RES_W].
REQ-012 res_tvalid_o / res_tready_i / res_tdata_o  out/in/out  1/1/RES_W  merged result stream.
REQ-013 res_wg_id_o  out  clog2(NUM_WG)  source workgroup of res_tdata_o.
REQ-014 outstanding_o  out  16  total jobs dispatched minus results returned.
REQ-015 idle_o  out  1  high when job buffer empty, result buffer empty, outstanding_o == 0.

Function
REQ-016 Job side SHALL be a one-entry buffer with states EMPTY and HOLD.
REQ-017 In EMPTY, job_tready_o SHALL be high only if some workgroup has credit[k] < MAX_OUTSTANDING.
REQ-018 On upstream handshake in EMPTY, SHALL capture job_tdata_i and target = first k with free credit, searching from job_ptr upward modulo NUM_WG; go to HOLD.
REQ-019 In HOLD, SHALL assert wg_job_tvalid_o[target] only, all other bits 0, job_tready_o 0; data and target stable until handshake.
REQ-020 On wg_job_tready_i[target] handshake, SHALL increment credit[target], set job_ptr = target+1 modulo NUM_WG, return to EMPTY.
REQ-021 Latency: job accepted at cycle N SHALL appear on wg_job_tvalid_o at cycle N+1; sustained throughput one job per 2 cycles.
REQ-022 Result side SHALL be a one-entry output register with round-robin arbiter; pointer res_ptr.
REQ-023 When the register is empty, SHALL grant the first k with wg_res_tvalid_i[k] searching from res_ptr, assert wg_res_tready_o[k] that cycle only, load data and k; res_tvalid_o rises next cycle.
REQ-024 At most one wg_res_tready_o bit SHALL be high per cycle, and none while res_tvalid_o is high and res_tready_i low.
REQ-025 On result load from k, SHALL decrement credit[k] and set res_ptr = k+1 modulo NUM_WG.
REQ-026 Output register SHALL empty on res_tvalid_o && res_tready_i; no reload in the same cycle (throughput one result per 2 cycles).
REQ-027 Simultaneous dispatch and result load on the same workgroup SHALL leave credit[k] unchanged; outstanding_o likewise.
REQ-028 Result arriving from a workgroup with credit[k] == 0 SHALL still be forwarded; credit saturates at 0.
REQ-029 Credit counters and outstanding_o SHALL saturate, never wrap.

Reset
REQ-030 On reset SHALL force: job state EMPTY, res register empty, job_ptr = res_ptr = 0, all credits 0, outstanding_o 0.
REQ-031 During and in the cycle after reset, SHALL drive job_tready_o 0 then 1, wg_job_tvalid_o 0, wg_res_tready_o 0, res_tvalid_o 0, idle_o 1 after reset.
REQ-032 Reset mid-transfer SHALL discard any buffered job or result without further handshake.

Verification
REQ-033 NUM_WG=4, all ready, 8 jobs back-to-back -> targets 0,1,2,3,0,1,2,3; outstanding_o 8; credit each 2.
REQ-034 MAX_OUTSTANDING=1, 5 jobs, no results -> 4 dispatched, job_tready_o 0 until WG2 returns a result, then 5th goes to WG2.
REQ-035 wg_job_tready_i[1] low 10 cycles while holding job for WG1 -> wg_job_tvalid_o[1] and data stable 10 cycles, no other WG asserted.
REQ-036 WG0..3 all assert results same cycle, res_tready_i high -> res_wg_id_o order 0,1,2,3, each data intact.
REQ-037 res_tready_i low 20 cycles with results pending -> one result held stable, no wg_res_tready_o pulses, no loss.
REQ-038 Reset asserted while HOLD and result register full -> next cycle all valids 0, outstanding_o 0, idle_o 1.

Source files
------------

// File: rtl/pairhmm_job_dispatcher_if.sv
// Handshake bundle between the PairHMM job dispatcher and its environment:
// upstream jobs, per-workgroup job/result channels and the merged result stream.
interface pairhmm_job_dispatcher_if #(
  parameter int unsigned NUM_WG = 4,
  parameter int unsigned JOB_W  = 256,
  parameter int unsigned RES_W  = 64
);
  localparam int unsigned IdW = (NUM_WG > 1) ? $clog2(NUM_WG) : 1;

  logic                    job_tvalid_i;
  logic                    job_tready_o;
  logic [JOB_W-1:0]        job_tdata_i;

  logic [NUM_WG-1:0]       wg_job_tvalid_o;
  logic [NUM_WG-1:0]       wg_job_tready_i;
  logic [JOB_W-1:0]        wg_job_tdata_o;

  logic [NUM_WG-1:0]       wg_res_tvalid_i;
  logic [NUM_WG-1:0]       wg_res_tready_o;
  logic [NUM_WG*RES_W-1:0] wg_res_tdata_i;

  logic                    res_tvalid_o;
  logic                    res_tready_i;
  logic [RES_W-1:0]        res_tdata_o;
  logic [IdW-1:0]          res_wg_id_o;

  logic [15:0]             outstanding_o;
  logic                    idle_o;

  // Dispatcher side.
  modport slave (
    input  job_tvalid_i, job_tdata_i, wg_job_tready_i, wg_res_tvalid_i, wg_res_tdata_i,
           res_tready_i,
    output job_tready_o, wg_job_tvalid_o, wg_job_tdata_o, wg_res_tready_o, res_tvalid_o,
           res_tdata_o, res_wg_id_o, outstanding_o, idle_o
  );

  // Environment side: upstream producer, workgroups and result consumer.
  modport master (
    output job_tvalid_i, job_tdata_i, wg_job_tready_i, wg_res_tvalid_i, wg_res_tdata_i,
           res_tready_i,
    input  job_tready_o, wg_job_tvalid_o, wg_job_tdata_o, wg_res_tready_o, res_tvalid_o,
           res_tdata_o, res_wg_id_o, outstanding_o, idle_o
  );
endinterface

// File: rtl/pairhmm_job_dispatcher.sv
// Credit-based job dispatcher for PairHMM workgroups: one-entry job buffer with
// round-robin target selection, and a one-entry round-robin merged result register.
module pairhmm_job_dispatcher #(
  parameter int unsigned NUM_WG          = 4,
  parameter int unsigned JOB_W           = 256,
  parameter int unsigned RES_W           = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                     clock,
  input logic                     reset,
  pairhmm_job_dispatcher_if.slave bus
);
  localparam int unsigned IdW   = (NUM_WG > 1) ? $clog2(NUM_WG) : 1;
  localparam int unsigned CredW = 4;
  localparam logic [CredW-1:0] CredMax = CredW'(MAX_OUTSTANDING);

  typedef enum logic {StEmpty, StHold} job_state_e;

  job_state_e        job_state_q;
  logic [JOB_W-1:0]  job_data_q;
  logic [IdW-1:0]    job_target_q;
  logic [IdW-1:0]    job_ptr_q;
  logic [NUM_WG-1:0] wg_job_valid_q;

  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic [IdW-1:0]    res_id_q;
  logic [IdW-1:0]    res_ptr_q;

  logic [CredW-1:0]  credit_q [NUM_WG];
  logic [15:0]       outstanding_q;

  // First set bit of req at or above ptr, wrapping modulo NUM_WG.
  function automatic logic [IdW-1:0] rr_pick(logic [NUM_WG-1:0] req, logic [IdW-1:0] ptr);
    logic [IdW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_WG; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_WG) idx = idx - NUM_WG;
      if (!found && req[IdW'(idx)]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [IdW-1:0] wrap_inc(logic [IdW-1:0] v);
    return (32'(v) >= NUM_WG - 1) ? '0 : v + IdW'(1);
  endfunction

  function automatic logic [NUM_WG-1:0] onehot(logic [IdW-1:0] v);
    return NUM_WG'(1) << v;
  endfunction

  logic [NUM_WG-1:0] wg_free, cred_nz, cred_inc, cred_dec, res_grant;
  logic [IdW-1:0]    job_pick, res_pick;
  logic [RES_W-1:0]  res_sel;
  logic              any_free, res_any;
  logic              job_accept, job_dispatch, res_load, res_pop;
  logic              out_inc, out_dec;

  always_comb begin
    wg_free = '0;
    cred_nz = '0;
    for (int unsigned k = 0; k < NUM_WG; k++) begin
      wg_free[k] = credit_q[k] < CredMax;
      cred_nz[k] = credit_q[k] != '0;
    end
    any_free     = |wg_free;
    res_any      = |bus.wg_res_tvalid_i;
    job_pick     = rr_pick(wg_free, job_ptr_q);
    res_pick     = rr_pick(bus.wg_res_tvalid_i, res_ptr_q);
    res_sel      = bus.wg_res_tdata_i[32'(res_pick) * RES_W +: RES_W];
    job_accept   = (job_state_q == StEmpty) && any_free && bus.job_tvalid_i;
    job_dispatch = (job_state_q == StHold) && bus.wg_job_tready_i[job_target_q];
    // A reload never happens in the cycle the register drains.
    res_load     = !res_valid_q && res_any;
    res_pop      = res_valid_q && bus.res_tready_i;
    res_grant    = res_load ? onehot(res_pick) : '0;
    cred_inc     = job_dispatch ? wg_job_valid_q : '0;
    cred_dec     = res_grant;
    // Outstanding tracks the credit sum: a result against a zero credit is not counted.
    out_inc      = job_dispatch;
    out_dec      = |(cred_dec & (cred_nz | cred_inc));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      job_state_q    <= StEmpty;
      job_data_q     <= '0;
      job_target_q   <= '0;
      job_ptr_q      <= '0;
      wg_job_valid_q <= '0;
    end else begin
      unique case (job_state_q)
        StEmpty: begin
          if (job_accept) begin
            job_data_q     <= bus.job_tdata_i;
            job_target_q   <= job_pick;
            wg_job_valid_q <= onehot(job_pick);
            job_state_q    <= StHold;
          end
        end
        StHold: begin
          if (job_dispatch) begin
            job_ptr_q      <= wrap_inc(job_target_q);
            wg_job_valid_q <= '0;
            job_state_q    <= StEmpty;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_ptr_q   <= '0;
    end else if (res_load) begin
      res_valid_q <= 1'b1;
      res_data_q  <= res_sel;
      res_id_q    <= res_pick;
      res_ptr_q   <= wrap_inc(res_pick);
    end else if (res_pop) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_WG; k++) credit_q[k] <= '0;
      outstanding_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WG; k++) begin
        if (cred_inc[k] && !cred_dec[k] && credit_q[k] != '1) begin
          credit_q[k] <= credit_q[k] + CredW'(1);
        end else if (cred_dec[k] && !cred_inc[k] && cred_nz[k]) begin
          credit_q[k] <= credit_q[k] - CredW'(1);
        end
      end
      if (out_inc && !out_dec && outstanding_q != 16'hFFFF) begin
        outstanding_q <= outstanding_q + 16'd1;
      end else if (out_dec && !out_inc && outstanding_q != 16'd0) begin
        outstanding_q <= outstanding_q - 16'd1;
      end
    end
  end

  // Handshake outputs are forced low while reset is held so nothing transfers.
  assign bus.job_tready_o    = !reset && (job_state_q == StEmpty) && any_free;
  assign bus.wg_job_tvalid_o = reset ? '0 : wg_job_valid_q;
  assign bus.wg_job_tdata_o  = job_data_q;
  assign bus.wg_res_tready_o = reset ? '0 : res_grant;
  assign bus.res_tvalid_o    = !reset && res_valid_q;
  assign bus.res_tdata_o     = res_data_q;
  assign bus.res_wg_id_o     = res_id_q;
  assign bus.outstanding_o   = outstanding_q;
  assign bus.idle_o          = (job_state_q == StEmpty) && !res_valid_q && (outstanding_q == 16'd0);

endmodule

// File: tb/tb_pairhmm_job_dispatcher.sv
// Directed, table-driven bench for pairhmm_job_dispatcher: a default instance
// (MAX_OUTSTANDING=4) and a single-credit instance (MAX_OUTSTANDING=1).
module tb_pairhmm_job_dispatcher;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pairhmm_job_dispatcher_if #(.NUM_WG(4), .JOB_W(256), .RES_W(64)) bus ();
  pairhmm_job_dispatcher_if #(.NUM_WG(4), .JOB_W(256), .RES_W(64)) bus1 ();

  pairhmm_job_dispatcher #(
    .NUM_WG(4), .JOB_W(256), .RES_W(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  pairhmm_job_dispatcher #(
    .NUM_WG(4), .JOB_W(256), .RES_W(64), .MAX_OUTSTANDING(1)
  ) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (bus1)
  );

  typedef struct {
    logic [255:0] data;
    logic [3:0]   exp_onehot;
    logic [15:0]  exp_out;
  } job_vec_t;

  typedef struct {
    logic [63:0] wg_data;
    logic [1:0]  exp_id;
    logic [63:0] exp_data;
  } res_vec_t;

  job_vec_t jv [8];
  res_vec_t rv [4];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] hs;
    int got;

    jv[0] = '{{8{32'hA000_0000}}, 4'b0001, 16'd1};
    jv[1] = '{{8{32'hA000_0001}}, 4'b0010, 16'd2};
    jv[2] = '{{8{32'hA000_0002}}, 4'b0100, 16'd3};
    jv[3] = '{{8{32'hA000_0003}}, 4'b1000, 16'd4};
    jv[4] = '{{8{32'hA000_0004}}, 4'b0001, 16'd5};
    jv[5] = '{{8{32'hA000_0005}}, 4'b0010, 16'd6};
    jv[6] = '{{8{32'hA000_0006}}, 4'b0100, 16'd7};
    jv[7] = '{{8{32'hA000_0007}}, 4'b1000, 16'd8};
    rv[0] = '{64'hD000_0000_0000_0000, 2'd0, 64'hD000_0000_0000_0000};
    rv[1] = '{64'hD111_1111_1111_1111, 2'd1, 64'hD111_1111_1111_1111};
    rv[2] = '{64'hD222_2222_2222_2222, 2'd2, 64'hD222_2222_2222_2222};
    rv[3] = '{64'hD333_3333_3333_3333, 2'd3, 64'hD333_3333_3333_3333};

    reset = 1'b1;
    bus.job_tvalid_i  = 1'b0;  bus.job_tdata_i    = '0;  bus.wg_job_tready_i = '0;
    bus.wg_res_tvalid_i = '0;  bus.wg_res_tdata_i = '0;  bus.res_tready_i    = 1'b0;
    bus1.job_tvalid_i = 1'b0;  bus1.job_tdata_i   = '0;  bus1.wg_job_tready_i = '0;
    bus1.wg_res_tvalid_i = '0; bus1.wg_res_tdata_i = '0; bus1.res_tready_i    = 1'b0;

    // Reset behaviour
    repeat (3) tick();
    check("rst_job_tready", bus.job_tready_o, 1'b0);
    check("rst_wg_job_tvalid", bus.wg_job_tvalid_o, 4'b0000);
    check("rst_res_tvalid", bus.res_tvalid_o, 1'b0);
    check("rst_wg_res_tready", bus.wg_res_tready_o, 4'b0000);
    reset = 1'b0;
    #1;
    check("post_rst_job_tready", bus.job_tready_o, 1'b1);
    check("post_rst_idle", bus.idle_o, 1'b1);
    check("post_rst_outstanding", bus.outstanding_o, 16'd0);

    // Result from a workgroup holding no credit is still forwarded
    bus.wg_res_tvalid_i = 4'b1000;
    bus.wg_res_tdata_i  = {64'hCAFE_0000_0000_0003, 192'h0};
    #1;
    check("zc_grant", bus.wg_res_tready_o, 4'b1000);
    tick();
    bus.wg_res_tvalid_i = '0;
    #1;
    check("zc_out", {bus.res_tvalid_o, bus.res_wg_id_o, bus.res_tdata_o},
          {1'b1, 2'd3, 64'hCAFE_0000_0000_0003});
    check("zc_outstanding", bus.outstanding_o, 16'd0);
    bus.res_tready_i = 1'b1;
    tick();
    check("zc_drained", bus.res_tvalid_o, 1'b0);
    check("zc_idle", bus.idle_o, 1'b1);

    // Eight back-to-back jobs, all workgroups ready
    bus.wg_job_tready_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.job_tvalid_i = 1'b1;
      bus.job_tdata_i  = jv[i].data;
      #1;
      check($sformatf("b2b_tready_%0d", i), bus.job_tready_o, 1'b1);
      tick();
      check($sformatf("b2b_target_%0d", i), bus.wg_job_tvalid_o, jv[i].exp_onehot);
      check($sformatf("b2b_data_%0d", i), bus.wg_job_tdata_o, jv[i].data);
      check($sformatf("b2b_hold_tready_%0d", i), bus.job_tready_o, 1'b0);
      if (i == 7) bus.job_tvalid_i = 1'b0;
      tick();
      check($sformatf("b2b_outstanding_%0d", i), bus.outstanding_o, jv[i].exp_out);
    end
    check("b2b_not_idle", bus.idle_o, 1'b0);

    // Stall WG1 for 10 cycles while its job is held
    bus.job_tvalid_i = 1'b1;
    bus.job_tdata_i  = {8{32'hB000_0000}};
    tick();
    check("stall_pre_target", bus.wg_job_tvalid_o, 4'b0001);
    tick();
    bus.wg_job_tready_i = 4'b1101;
    bus.job_tdata_i     = {8{32'hB000_0001}};
    tick();
    bus.job_tvalid_i = 1'b0;
    bus.job_tdata_i  = '0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall_valid_%0d", c), bus.wg_job_tvalid_o, 4'b0010);
      check($sformatf("stall_data_%0d", c), bus.wg_job_tdata_o, {8{32'hB000_0001}});
      tick();
    end
    bus.wg_job_tready_i = 4'hF;
    tick();
    check("stall_released", bus.wg_job_tvalid_o, 4'b0000);
    check("stall_outstanding", bus.outstanding_o, 16'd10);

    // All four workgroups return results in the same cycle
    bus.wg_res_tdata_i  = {rv[3].wg_data, rv[2].wg_data, rv[1].wg_data, rv[0].wg_data};
    bus.wg_res_tvalid_i = 4'hF;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clock);
      check($sformatf("rr_one_grant_%0d", c), $countones(bus.wg_res_tready_o) <= 1, 1'b1);
      hs = bus.wg_res_tvalid_i & bus.wg_res_tready_o;
      if (bus.res_tvalid_o) begin
        check($sformatf("rr_id_%0d", got), bus.res_wg_id_o, rv[got].exp_id);
        check($sformatf("rr_data_%0d", got), bus.res_tdata_o, rv[got].exp_data);
        got++;
      end
      @(posedge clock);
      #1;
      bus.wg_res_tvalid_i = bus.wg_res_tvalid_i & ~hs;
    end
    check("rr_count", got, 4);
    check("rr_outstanding", bus.outstanding_o, 16'd6);

    // Consumer back-pressure for 20 cycles
    bus.res_tready_i    = 1'b0;
    bus.wg_res_tdata_i  = {64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002, 128'h0};
    bus.wg_res_tvalid_i = 4'b1100;
    tick();
    bus.wg_res_tvalid_i = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("bp_hold_%0d", c),
            {bus.res_tvalid_o, bus.res_wg_id_o, bus.wg_res_tready_o, bus.res_tdata_o},
            {1'b1, 2'd2, 4'b0000, 64'hBEEF_0000_0000_0002});
      tick();
    end
    bus.res_tready_i = 1'b1;
    tick();
    check("bp_next_grant", bus.wg_res_tready_o, 4'b1000);
    tick();
    bus.wg_res_tvalid_i = '0;
    check("bp_second", {bus.res_tvalid_o, bus.res_wg_id_o, bus.res_tdata_o},
          {1'b1, 2'd3, 64'hBEEF_0000_0000_0003});
    tick();
    check("bp_drained", bus.res_tvalid_o, 1'b0);
    check("bp_outstanding", bus.outstanding_o, 16'd4);

    // Dispatch and result load on WG2 in the same cycle
    bus.wg_job_tready_i = 4'b0000;
    bus.job_tvalid_i    = 1'b1;
    bus.job_tdata_i     = {8{32'hC000_0002}};
    tick();
    bus.job_tvalid_i = 1'b0;
    check("sim_target", bus.wg_job_tvalid_o, 4'b0100);
    bus.wg_job_tready_i = 4'hF;
    bus.wg_res_tdata_i  = {64'h0, 64'hF00D_0000_0000_0002, 128'h0};
    bus.wg_res_tvalid_i = 4'b0100;
    #1;
    check("sim_grant", bus.wg_res_tready_o, 4'b0100);
    tick();
    bus.wg_res_tvalid_i = '0;
    check("sim_dispatched", bus.wg_job_tvalid_o, 4'b0000);
    check("sim_res", {bus.res_tvalid_o, bus.res_wg_id_o}, {1'b1, 2'd2});
    check("sim_outstanding", bus.outstanding_o, 16'd4);
    tick();

    // Reset while a job is held and the result register is full
    bus.res_tready_i    = 1'b0;
    bus.wg_job_tready_i = 4'b0000;
    bus.job_tvalid_i    = 1'b1;
    bus.job_tdata_i     = {8{32'hE000_0003}};
    bus.wg_res_tdata_i  = {192'h0, 64'hE5E5_0000_0000_0000};
    bus.wg_res_tvalid_i = 4'b0001;
    tick();
    bus.job_tvalid_i    = 1'b0;
    bus.wg_res_tvalid_i = '0;
    check("mid_hold", bus.wg_job_tvalid_o, 4'b1000);
    check("mid_res", {bus.res_tvalid_o, bus.res_wg_id_o}, {1'b1, 2'd0});
    check("mid_outstanding", bus.outstanding_o, 16'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_valids", {bus.job_tready_o, bus.wg_job_tvalid_o, bus.res_tvalid_o}, 6'b0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_after_valids", {bus.wg_job_tvalid_o, bus.res_tvalid_o, bus.wg_res_tready_o}, 9'b0);
    check("mid_after_outstanding", bus.outstanding_o, 16'd0);
    check("mid_after_idle", bus.idle_o, 1'b1);
    check("mid_after_tready", bus.job_tready_o, 1'b1);

    // Single-credit instance: five jobs, no results until WG2 returns one
    bus1.wg_job_tready_i = 4'hF;
    bus1.res_tready_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.job_tvalid_i = 1'b1;
      bus1.job_tdata_i  = jv[i].data;
      #1;
      check($sformatf("mo1_tready_%0d", i), bus1.job_tready_o, 1'b1);
      tick();
      check($sformatf("mo1_target_%0d", i), bus1.wg_job_tvalid_o, jv[i].exp_onehot);
      tick();
    end
    bus1.job_tdata_i = {8{32'hF000_0005}};
    for (int c = 0; c < 5; c++) begin
      check($sformatf("mo1_blocked_%0d", c), bus1.job_tready_o, 1'b0);
      tick();
    end
    check("mo1_outstanding_full", bus1.outstanding_o, 16'd4);
    bus1.wg_res_tdata_i  = {64'h0, 64'h5555_0000_0000_0002, 128'h0};
    bus1.wg_res_tvalid_i = 4'b0100;
    #1;
    check("mo1_res_grant", bus1.wg_res_tready_o, 4'b0100);
    tick();
    bus1.wg_res_tvalid_i = '0;
    check("mo1_tready_back", bus1.job_tready_o, 1'b1);
    tick();
    bus1.job_tvalid_i = 1'b0;
    check("mo1_fifth_target", bus1.wg_job_tvalid_o, 4'b0100);
    check("mo1_fifth_data", bus1.wg_job_tdata_o, {8{32'hF000_0005}});
    tick();
    check("mo1_outstanding_end", bus1.outstanding_o, 16'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
